// File: rtl/tc_sram_bank_pwr_ctrl.sv
// Per-logic-bank power controller in front of tc_sram_multibank: tracks bank activity,
// drives deepsleep/powergate and gates requests to banks that are asleep, waking or off.
module tc_sram_bank_pwr_ctrl #(
    parameter int unsigned NumWords      = 1024,
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned NumLogicBanks = 4,
    parameter int unsigned Latency       = 1,
    parameter int unsigned IdleCycles    = 16,
    parameter int unsigned WakeCycles    = 4,
    localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BankSelWidth = $clog2(NumLogicBanks)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             err_o,
    output logic [NumPorts-1:0]             req_o,
    input  logic [NumLogicBanks-1:0]        pwr_off_i,
    output logic [NumLogicBanks-1:0]        deepsleep_o,
    output logic [NumLogicBanks-1:0]        powergate_o,
    output logic [2*NumLogicBanks-1:0]      bank_state_o
);

    localparam int unsigned IdleMax = (IdleCycles > Latency) ? IdleCycles : Latency;
    localparam int unsigned IdleW   = $clog2(IdleMax) + 1;
    localparam int unsigned WakeW   = $clog2(WakeCycles) + 1;

    localparam logic [IdleW-1:0] IdleSat     = IdleW'(IdleMax);
    localparam logic [IdleW-1:0] IdleSleepAt = IdleW'((IdleCycles != 0) ? IdleCycles - 1 : 0);
    localparam logic [IdleW-1:0] IdleLat     = IdleW'(Latency);
    localparam logic [WakeW-1:0] WakeInit    = WakeW'(WakeCycles - 1);

    if ((NumLogicBanks < 2) || ((NumLogicBanks & (NumLogicBanks - 1)) != 0)) begin : gen_bad_banks
        $fatal(1, "NumLogicBanks must be a power of two and at least 2");
    end
    if (WakeCycles == 0) begin : gen_bad_wake
        $fatal(1, "WakeCycles must be at least 1");
    end
    if ((IdleCycles != 0) && (IdleCycles < Latency)) begin : gen_bad_idle
        $fatal(1, "IdleCycles must be 0 or at least Latency");
    end

    typedef enum logic [1:0] {
        StActive = 2'd0,
        StSleep  = 2'd1,
        StWake   = 2'd2,
        StOff    = 2'd3
    } bank_state_e;

    bank_state_e      state_q    [NumLogicBanks];
    bank_state_e      state_d    [NumLogicBanks];
    logic [IdleW-1:0] idle_cnt_q [NumLogicBanks];
    logic [IdleW-1:0] idle_cnt_d [NumLogicBanks];
    logic [WakeW-1:0] wake_cnt_q [NumLogicBanks];
    logic [WakeW-1:0] wake_cnt_d [NumLogicBanks];

    logic [BankSelWidth-1:0]  port_bank [NumPorts];
    logic [NumLogicBanks-1:0] hit;

    // Only the bank-select field of the address is decoded here.
    logic unused_addr;
    assign unused_addr = ^addr_i;

    always_comb begin
        hit = '0;
        for (int p = 0; p < NumPorts; p++) begin
            port_bank[p] = addr_i[p*AddrWidth + AddrWidth - 1 -: BankSelWidth];
            if (req_i[p]) begin
                hit[port_bank[p]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int b = 0; b < NumLogicBanks; b++) begin
                state_q[b]    <= StActive;
                idle_cnt_q[b] <= '0;
                wake_cnt_q[b] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    always_comb begin
        for (int b = 0; b < NumLogicBanks; b++) begin
            state_d[b]    = state_q[b];
            idle_cnt_d[b] = idle_cnt_q[b];
            wake_cnt_d[b] = wake_cnt_q[b];
            case (state_q[b])
                StActive: begin
                    if (hit[b]) begin
                        idle_cnt_d[b] = '0;
                    end else begin
                        if (idle_cnt_q[b] != IdleSat) begin
                            idle_cnt_d[b] = idle_cnt_q[b] + 1'b1;
                        end
                        // Power-off waits for in-flight reads to drain; it beats auto-sleep.
                        if (pwr_off_i[b] && (idle_cnt_q[b] >= IdleLat)) begin
                            state_d[b] = StOff;
                        end else if ((IdleCycles != 0) && (idle_cnt_q[b] == IdleSleepAt)) begin
                            state_d[b] = StSleep;
                        end
                    end
                end
                StSleep: begin
                    if (pwr_off_i[b]) begin
                        state_d[b] = StOff;
                    end else if (hit[b]) begin
                        state_d[b]    = StWake;
                        wake_cnt_d[b] = WakeInit;
                    end
                end
                StWake: begin
                    if (wake_cnt_q[b] == '0) begin
                        state_d[b]    = StActive;
                        idle_cnt_d[b] = '0;
                    end else begin
                        wake_cnt_d[b] = wake_cnt_q[b] - 1'b1;
                    end
                end
                StOff: begin
                    if (!pwr_off_i[b]) begin
                        state_d[b]    = StWake;
                        wake_cnt_d[b] = WakeInit;
                    end
                end
                default: state_d[b] = StActive;
            endcase
        end
    end

    always_comb begin
        deepsleep_o  = '0;
        powergate_o  = '0;
        bank_state_o = '0;
        for (int b = 0; b < NumLogicBanks; b++) begin
            deepsleep_o[b]        = (state_q[b] == StSleep);
            powergate_o[b]        = (state_q[b] == StOff);
            bank_state_o[2*b +: 2] = state_q[b];
        end
        gnt_o = '0;
        err_o = '0;
        req_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            case (state_q[port_bank[p]])
                StActive: begin
                    gnt_o[p] = req_i[p];
                    req_o[p] = req_i[p];
                end
                // An off bank answers immediately with an error instead of stalling the port.
                StOff: begin
                    gnt_o[p] = req_i[p];
                    err_o[p] = req_i[p];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_sram_bank_pwr_ctrl.sv
// Bench for tc_sram_bank_pwr_ctrl: timestamp-based bank model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tc_sram_bank_pwr_ctrl;

    localparam int NP   = 2;
    localparam int NB   = 4;
    localparam int AW   = 10;
    localparam int LAT  = 1;
    localparam int IDLE = 16;
    localparam int WAKE = 4;

    localparam int StA = 0;
    localparam int StS = 1;
    localparam int StW = 2;
    localparam int StO = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   req = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NB-1:0]   pwr_off = '0;
    logic [NP-1:0]   gnt, err, req_fwd;
    logic [NB-1:0]   ds, pg;
    logic [2*NB-1:0] bstate;

    always #5 clk = ~clk;

    tc_sram_bank_pwr_ctrl #(
        .NumWords     (1024),
        .NumPorts     (NP),
        .NumLogicBanks(NB),
        .Latency      (LAT),
        .IdleCycles   (IDLE),
        .WakeCycles   (WAKE)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .addr_i      (addr),
        .gnt_o       (gnt),
        .err_o       (err),
        .req_o       (req_fwd),
        .pwr_off_i   (pwr_off),
        .deepsleep_o (ds),
        .powergate_o (pg),
        .bank_state_o(bstate)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: each bank keeps a state plus the cycle its idle count restarted and the
    // cycle at which a wake-up completes; counts are derived from the cycle number.
    int cyc = 0;
    bit mvalid = 1'b0;
    int mst      [NB];
    int last_ref [NB];
    int act_at   [NB];

    function automatic bit hit_of(input int b);
        for (int p = 0; p < NP; p++) begin
            if (req[p] && (int'(addr[p*AW + AW - 1 -: 2]) == b)) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        mvalid <= 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (!rst_n) begin
                mst[b]      <= StA;
                last_ref[b] <= cyc + 1;
            end else begin
                case (mst[b])
                    StA: begin
                        if (hit_of(b)) last_ref[b] <= cyc + 1;
                        else if (pwr_off[b] && (cyc - last_ref[b]) >= LAT) mst[b] <= StO;
                        else if ((cyc - last_ref[b]) == IDLE - 1) mst[b] <= StS;
                    end
                    StS: begin
                        if (pwr_off[b]) mst[b] <= StO;
                        else if (hit_of(b)) begin
                            mst[b]    <= StW;
                            act_at[b] <= cyc + 1 + WAKE;
                        end
                    end
                    StW: begin
                        if (cyc + 1 == act_at[b]) begin
                            mst[b]      <= StA;
                            last_ref[b] <= cyc + 1;
                        end
                    end
                    default: begin
                        if (!pwr_off[b]) begin
                            mst[b]    <= StW;
                            act_at[b] <= cyc + 1 + WAKE;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [NB-1:0]   eds, epg;
        logic [2*NB-1:0] ebs;
        logic [NP-1:0]   eg, ee, er;
        int bk;
        if (mvalid) begin
            for (int b = 0; b < NB; b++) begin
                eds[b]         = (mst[b] == StS);
                epg[b]         = (mst[b] == StO);
                ebs[2*b +: 2]  = mst[b][1:0];
            end
            for (int p = 0; p < NP; p++) begin
                bk    = int'(addr[p*AW + AW - 1 -: 2]);
                eg[p] = req[p] && (mst[bk] == StA || mst[bk] == StO);
                ee[p] = req[p] && (mst[bk] == StO);
                er[p] = req[p] && (mst[bk] == StA);
            end
            chk("model gnt_o", gnt, eg);
            chk("model err_o", err, ee);
            chk("model req_o", req_fwd, er);
            chk("model deepsleep_o", ds, eds);
            chk("model powergate_o", pg, epg);
            chk("model bank_state_o", bstate, ebs);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input logic [AW-1:0] a);
        req[p]             = r;
        addr[p*AW +: AW]   = a;
    endtask

    initial begin
        // 1: reset, no traffic -> all banks asleep at cycle 17 after release
        tick(2);
        rst_n = 1'b1;
        tick(15);
        settle();
        chk("t1 c16 bank_state", bstate, 8'h00);
        chk("t1 c16 deepsleep", ds, 4'h0);
        tick(1);
        settle();
        chk("t1 c17 bank_state", bstate, 8'h55);
        chk("t1 c17 deepsleep", ds, 4'hF);

        // 2: wake bank 2 from port 0
        set_port(0, 1'b1, 10'h200);
        settle();
        chk("t2 t gnt", gnt, 2'b00);
        tick(1);
        settle();
        chk("t2 t+1 bank2 WAKE", bstate[5:4], 2'd2);
        tick(3);
        settle();
        chk("t2 t+4 gnt0", gnt[0], 1'b0);
        tick(1);
        settle();
        chk("t2 t+5 gnt0", gnt[0], 1'b1);
        chk("t2 t+5 req_o0", req_fwd[0], 1'b1);
        tick(1);
        set_port(0, 1'b0, 10'h200);

        // 3: periodic accesses keep bank 1 awake
        set_port(0, 1'b1, 10'h100);
        tick(5);
        settle();
        chk("t3 wake gnt0", gnt[0], 1'b1);
        tick(1);
        set_port(0, 1'b0, 10'h100);
        for (int i = 0; i < 3; i++) begin
            tick(9);
            set_port(0, 1'b1, 10'h100);
            settle();
            chk("t3 pulse bank1 ACTIVE", bstate[3:2], 2'd0);
            chk("t3 pulse gnt0", gnt[0], 1'b1);
            tick(1);
            set_port(0, 1'b0, 10'h100);
        end
        tick(15);
        settle();
        chk("t3 t+16 bank1 ACTIVE", bstate[3:2], 2'd0);
        tick(1);
        settle();
        chk("t3 t+17 bank1 SLEEP", bstate[3:2], 2'd1);

        // 4: power off bank 3 while active, access it, then power it back on
        set_port(0, 1'b1, 10'h3F0);
        tick(5);
        settle();
        chk("t4 wake gnt0", gnt[0], 1'b1);
        tick(1);
        set_port(0, 1'b0, 10'h3F0);
        pwr_off[3] = 1'b1;
        tick(1);
        settle();
        chk("t4 drain bank3 ACTIVE", bstate[7:6], 2'd0);
        chk("t4 drain powergate", pg[3], 1'b0);
        tick(1);
        settle();
        chk("t4 bank3 OFF", bstate[7:6], 2'd3);
        chk("t4 powergate", pg[3], 1'b1);
        set_port(0, 1'b1, 10'h3F0);
        settle();
        chk("t4 off gnt0", gnt[0], 1'b1);
        chk("t4 off err0", err[0], 1'b1);
        chk("t4 off req_o0", req_fwd[0], 1'b0);
        tick(1);
        set_port(0, 1'b0, 10'h3F0);
        pwr_off[3] = 1'b0;
        tick(1);
        settle();
        chk("t4 u+1 bank3 WAKE", bstate[7:6], 2'd2);
        tick(3);
        settle();
        chk("t4 u+4 bank3 WAKE", bstate[7:6], 2'd2);
        tick(1);
        settle();
        chk("t4 u+5 bank3 ACTIVE", bstate[7:6], 2'd0);

        // 5: one port hits an active bank, the other a sleeping one
        settle();
        chk("t5 bank2 SLEEP", bstate[5:4], 2'd1);
        set_port(0, 1'b1, 10'h000);
        tick(5);
        settle();
        chk("t5 bank0 wake gnt0", gnt[0], 1'b1);
        tick(1);
        set_port(1, 1'b1, 10'h200);
        settle();
        chk("t5 s gnt", gnt, 2'b01);
        tick(1);
        set_port(0, 1'b0, 10'h000);
        tick(3);
        settle();
        chk("t5 s+4 gnt1", gnt[1], 1'b0);
        tick(1);
        settle();
        chk("t5 s+5 gnt1", gnt[1], 1'b1);
        chk("t5 s+5 req_o1", req_fwd[1], 1'b1);
        tick(1);
        set_port(1, 1'b0, 10'h200);

        // 6: reset in the middle of a wake-up
        tick(20);
        settle();
        chk("t6 bank0 SLEEP", bstate[1:0], 2'd1);
        set_port(0, 1'b1, 10'h000);
        tick(1);
        set_port(0, 1'b0, 10'h000);
        settle();
        chk("t6 bank0 WAKE", bstate[1:0], 2'd2);
        rst_n = 1'b0;
        tick(1);
        settle();
        chk("t6 reset bank_state", bstate, 8'h00);
        chk("t6 reset deepsleep", ds, 4'h0);
        chk("t6 reset powergate", pg, 4'h0);
        rst_n = 1'b1;
        tick(15);
        settle();
        chk("t6 c16 bank_state", bstate, 8'h00);
        tick(1);
        settle();
        chk("t6 c17 bank_state", bstate, 8'h55);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
